// File: rtl/game_pkg.sv
// Shared definitions for the game status keeper: FSM state encoding and the
// default game constants used as parameter defaults by game_status_unit.
// No logic, no latency, no flow control.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        DYING = 2'd1,
        OVER  = 2'd2,
        WON   = 2'd3
    } state_t;

    localparam int TIME_START_DEF = 300;
    localparam int LIVES_MAX_DEF  = 3;
    localparam int COIN_VALUE_DEF = 10;

endpackage

// File: rtl/game_status_unit_event_sync.sv
// event_sync: 2-FF synchroniser for a level flag from another clock domain plus
// a rising-edge detector; pulse is high for one clk cycle per edge.
// Latency: pulse is high in the cycle after the 2nd clk edge that sees the level; no backpressure.
// Ports: clk, rst (async, active high), din (async level), pulse (one-cycle edge strobe).
module event_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    // prev is the registered copy of sync, so this is high for exactly one cycle per rising edge.
    assign pulse = sync & ~prev;

endmodule

// File: rtl/game_status_unit.sv
// game_status_unit: keeps score, level timer and lives; four-state PLAY/DYING/OVER/WON FSM,
// thermometer lives LEDs and a one-cycle respawn strobe for the player controller.
// Latency: input flag to output change 3 clk edges (2 sync + edge reg); all outputs registered; no backpressure.
// Ports: clk, rst (async high); coin_det/outbounds/game_win (async levels), start (clk-synchronous);
//        score, g_time, lives, lives_led, state, respawn (registered outputs).
// Build option: GAME_STATUS_TIME_BONUS_EN converts remaining time into score, one unit per cycle, in WON.
module game_status_unit
    import game_pkg::*;
#(
    parameter  int TICK_DIV   = 100_000_000,
    parameter  int SCORE_W    = 14,
    parameter  int SCORE_MAX  = 9999,
    parameter  int TIME_W     = 9,
    parameter  int TIME_START = TIME_START_DEF,
    parameter  int LIVES_MAX  = LIVES_MAX_DEF,
    parameter  int COIN_VALUE = COIN_VALUE_DEF,
    parameter  int DEATH_HOLD = 50_000_000,
    localparam int LIVES_W    = $clog2(LIVES_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_det,
    input  logic                 outbounds,
    input  logic                 game_win,
    input  logic                 start,
    output logic [SCORE_W-1:0]   score,
    output logic [TIME_W-1:0]    g_time,
    output logic [LIVES_W-1:0]   lives,
    output logic [LIVES_MAX-1:0] lives_led,
    output logic [1:0]           state,
    output logic                 respawn
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    localparam int HOLD_W = $clog2(DEATH_HOLD + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DEATH_HOLD - 1);

    logic coin_edge;
    logic out_edge;
    logic win_edge;

    event_sync u_coin_sync (.clk(clk), .rst(rst), .din(coin_det),  .pulse(coin_edge));
    event_sync u_out_sync  (.clk(clk), .rst(rst), .din(outbounds), .pulse(out_edge));
    event_sync u_win_sync  (.clk(clk), .rst(rst), .din(game_win),  .pulse(win_edge));

    state_t               state_q,     state_d;
    logic [SCORE_W-1:0]   score_q,     score_d;
    logic [TIME_W-1:0]    g_time_q,    g_time_d;
    logic [LIVES_W-1:0]   lives_q,     lives_d;
    logic [LIVES_MAX-1:0] lives_led_q, lives_led_d;
    logic [TICK_W-1:0]    tick_q,      tick_d;
    logic [HOLD_W-1:0]    hold_q,      hold_d;
    logic                 respawn_q,   respawn_d;

    logic timeout;
    logic died;
    logic restart;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int inc);
        int s;
        s = int'(a) + inc;
        if (s > SCORE_MAX) begin
            s = SCORE_MAX;
        end
        return SCORE_W'(s);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PLAY;
            score_q     <= '0;
            g_time_q    <= TIME_W'(TIME_START);
            lives_q     <= LIVES_W'(LIVES_MAX);
            lives_led_q <= '1;
            tick_q      <= '0;
            hold_q      <= '0;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            g_time_q    <= g_time_d;
            lives_q     <= lives_d;
            lives_led_q <= lives_led_d;
            tick_q      <= tick_d;
            hold_q      <= hold_d;
            respawn_q   <= respawn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        g_time_d    = g_time_q;
        lives_d     = lives_q;
        lives_led_d = lives_led_q;
        tick_d      = tick_q;
        hold_d      = hold_q;
        respawn_d   = 1'b0;
        timeout     = 1'b0;
        died        = 1'b0;
        restart     = 1'b0;

        unique case (state_q)
            PLAY: begin
                // A coin is scored even when a death or win lands in the same cycle.
                if (coin_edge) begin
                    score_d = sat_add(score_q, COIN_VALUE);
                end
                if (win_edge) begin
                    // Win outranks any simultaneous death; timer freezes from here on.
                    state_d = WON;
                end else begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (g_time_q != '0) begin
                            g_time_d = g_time_q - TIME_W'(1);
                        end
                        timeout = (g_time_q == TIME_W'(1));
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    // Time-out and out-of-bounds together cost a single life.
                    died = timeout | out_edge;
                    if (died) begin
                        lives_d = lives_q - LIVES_W'(1);
                        if (lives_q <= LIVES_W'(1)) begin
                            lives_d = '0;
                            state_d = OVER;
                        end else begin
                            state_d = DYING;
                            hold_d  = '0;
                        end
                    end
                end
            end
            DYING: begin
                if (hold_q == HOLD_LAST) begin
                    state_d   = PLAY;
                    respawn_d = 1'b1;
                    g_time_d  = TIME_W'(TIME_START);
                    tick_d    = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            OVER: begin
                restart = start;
            end
            WON: begin
`ifdef GAME_STATUS_TIME_BONUS_EN
                // Drain the remaining time into the score before a restart is accepted.
                if (g_time_q != '0) begin
                    g_time_d = g_time_q - TIME_W'(1);
                    score_d  = sat_add(score_q, 1);
                end else begin
                    restart = start;
                end
`else
                restart = start;
`endif
            end
            default: begin
                state_d = PLAY;
            end
        endcase

        if (restart) begin
            state_d   = PLAY;
            score_d   = '0;
            g_time_d  = TIME_W'(TIME_START);
            lives_d   = LIVES_W'(LIVES_MAX);
            tick_d    = '0;
            hold_d    = '0;
            respawn_d = 1'b1;
        end

        for (int i = 0; i < LIVES_MAX; i++) begin
            lives_led_d[i] = (int'(lives_d) > i);
        end
    end

    assign score     = score_q;
    assign g_time    = g_time_q;
    assign lives     = lives_q;
    assign lives_led = lives_led_q;
    assign state     = state_q;
    assign respawn   = respawn_q;

endmodule
